// File: rtl/j_pcseq_pkg.sv
// rtl/j_pcseq_pkg.sv - shared types, widths and helpers for the Jerry DSP PC sequencer
package j_pcseq_pkg;

    localparam int J_AW        = 23;
    localparam int J_VEC_SHIFT = 3;

    typedef enum logic {
        RUN  = 1'b0,
        SLOT = 1'b1
    } pcseq_state_t;

    function automatic logic [J_AW-1:0] sext5(input logic [4:0] v);
        return {{(J_AW-5){v[4]}}, v};
    endfunction

endpackage

// File: rtl/j_pcseq_opmux.sv
// rtl/j_pcseq_opmux.sv - operand select for the external 23-bit adder (vector, relative target, increment)
module j_pcseq_opmux
    import j_pcseq_pkg::*;
#(
    parameter logic [J_AW-1:0] VEC_BASE  = 23'h78D800,
    parameter int              VEC_SHIFT = J_VEC_SHIFT
) (
    input  logic            int_sel,
    input  logic            rel_sel,
    input  logic [J_AW-1:0] pc,
    input  logic [4:0]      br_off,
    input  logic [2:0]      int_num,
    output logic [J_AW-1:0] add_a,
    output logic [J_AW-1:0] add_b
);

    always_comb begin
        add_a = pc;
        add_b = J_AW'(1);
        if (int_sel) begin
            add_a = VEC_BASE;
            add_b = J_AW'(int_num) << VEC_SHIFT;
        end else if (rel_sel) begin
            // JR target is relative to the slot address, hence the +1
            add_b = sext5(br_off) + J_AW'(1);
        end
    end

endmodule

// File: rtl/j_pcseq.sv
// rtl/j_pcseq.sv - Jerry DSP program-counter sequencer with delayed branches and interrupt entry
// Optional single-step input enabled by defining J_PCSEQ_SSTEP_EN.
module j_pcseq
    import j_pcseq_pkg::*;
#(
    parameter int            AW        = J_AW,
    parameter logic [AW-1:0] RESET_PC  = 23'h78D800,
    parameter logic [AW-1:0] VEC_BASE  = 23'h78D800,
    parameter int            VEC_SHIFT = J_VEC_SHIFT
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          go,
    input  logic          stall,
`ifdef J_PCSEQ_SSTEP_EN
    input  logic          sstep,
`endif
    output logic          fetch_req,
    input  logic          fetch_ack,
    output logic [AW-1:0] pc,
    input  logic          br_rel,
    input  logic          br_abs,
    input  logic [4:0]    br_off,
    input  logic [AW-1:0] br_tgt,
    output logic          br_err,
    input  logic          int_req,
    input  logic [2:0]    int_num,
    output logic          int_ack,
    output logic [AW-1:0] ret_pc,
    output logic [AW-1:0] add_a,
    output logic [AW-1:0] add_b,
    input  logic [AW-1:0] add_s
);

    pcseq_state_t  state, state_d;
    logic [AW-1:0] tgt, tgt_d, pc_d, ret_d, pc_inc;
    logic          br_err_d, int_ack_d, int_armed, armed_d;
    logic          active, int_allow, adv, in_run, any_br, rel_sel, int_take;

`ifdef J_PCSEQ_SSTEP_EN
    logic sstep_q, step_pend;

    // A step edge is remembered until the fetch it unlocks is accepted
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sstep_q   <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            sstep_q <= sstep;
            if (sstep & ~sstep_q & ~go)
                step_pend <= 1'b1;
            else if (adv & ~go)
                step_pend <= 1'b0;
        end
    end

    assign active    = ~stall & (go | step_pend);
    assign int_allow = go;
`else
    assign active    = go & ~stall;
    assign int_allow = 1'b1;
`endif

    assign fetch_req = active & ~reset;
    assign adv       = fetch_req & fetch_ack;
    assign in_run    = (state == RUN);
    assign any_br    = br_rel | br_abs;
    assign rel_sel   = in_run & br_rel & ~br_abs;
    assign int_take  = adv & in_run & ~any_br & int_req & int_armed & int_allow;
    // Dedicated incrementer keeps the adder free for branch targets and vectors
    assign pc_inc    = pc + AW'(1);

    j_pcseq_opmux #(
        .VEC_BASE  (VEC_BASE),
        .VEC_SHIFT (VEC_SHIFT)
    ) u_opmux (
        .int_sel (int_take),
        .rel_sel (rel_sel),
        .pc      (pc),
        .br_off  (br_off),
        .int_num (int_num),
        .add_a   (add_a),
        .add_b   (add_b)
    );

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        tgt_d     = tgt;
        ret_d     = ret_pc;
        br_err_d  = 1'b0;
        int_ack_d = 1'b0;
        armed_d   = int_armed;

        if (int_take)
            armed_d = 1'b0;
        else if (active & ~int_req)
            armed_d = 1'b1;

        if (adv) begin
            case (state)
                RUN: begin
                    if (br_abs) begin
                        tgt_d    = br_tgt;
                        pc_d     = pc_inc;
                        state_d  = SLOT;
                        br_err_d = br_rel;
                    end else if (br_rel) begin
                        tgt_d   = add_s;
                        pc_d    = pc_inc;
                        state_d = SLOT;
                    end else if (int_take) begin
                        ret_d     = pc_inc;
                        pc_d      = add_s;
                        int_ack_d = 1'b1;
                    end else begin
                        pc_d = add_s;
                    end
                end
                SLOT: begin
                    pc_d     = tgt;
                    state_d  = RUN;
                    br_err_d = any_br;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            pc        <= RESET_PC;
            tgt       <= '0;
            ret_pc    <= '0;
            br_err    <= 1'b0;
            int_ack   <= 1'b0;
            int_armed <= 1'b1;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            tgt       <= tgt_d;
            ret_pc    <= ret_d;
            br_err    <= br_err_d;
            int_ack   <= int_ack_d;
            int_armed <= armed_d;
        end
    end

endmodule
